// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interrupt timer: register offsets,
// reset constants, register/response encodings and the byte-merge helper.
package clint_pkg;

    // Byte offsets of the registers inside the timer region
    localparam logic [15:0] CLINT_MSIP_OFF        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO_OFF = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI_OFF = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO_OFF    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI_OFF    = 16'hBFFC;

    // mtimecmp resets to all ones so MTIP stays low until software programs it
    localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // Decoded register selected by a bus request
    typedef enum logic [2:0] {
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_TIME_LO,
        REG_TIME_HI,
        REG_NONE
    } clint_reg_e;

    // Response channel state: idle, or holding a response until rsp_ready
    typedef enum logic {
        RSP_IDLE,
        RSP_PEND
    } rsp_state_e;

    // Replace the bytes of old_w selected by wstrb with the matching bytes of wdata
    function automatic logic [31:0] clint_merge(input logic [31:0] old_w,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        res = old_w;
        for (int unsigned i = 0; i < 4; i++) begin
            if (wstrb[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_prescaler.sv
// mtime tick generator: counts 0..PRESCALE-1 and pulses tick on the last
// count. Only instantiated when CLINT_PRESCALE_EN is defined.
module clint_prescaler #(
    parameter int unsigned PRESCALE = 10
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned    CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Tick on the terminal count, then restart from zero
    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clint_timer.sv
// Core-local interrupt timer: 64-bit mtime / mtimecmp, msip, and a single
// outstanding-response bus slave. Drives MTIP (timer_irq) and MSIP (sw_irq).
// Optional build macro: CLINT_PRESCALE_EN (mtime advances once per PRESCALE
// clocks instead of every clock).
module clint_timer
    import clint_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned PRESCALE = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              timer_irq,
    output logic              sw_irq
);

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic        timer_irq_q, timer_irq_d;

    rsp_state_e  rsp_state_q, rsp_state_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        tick;
    logic        accept;
    clint_reg_e  sel;
    logic [31:0] rd_word;
    logic [31:0] wr_word;

`ifdef CLINT_PRESCALE_EN
    clint_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );
`else
    // Without the prescaler mtime advances every clock (PRESCALE >= 1 always holds)
    assign tick = (PRESCALE != 0);
`endif

    assign req_ready = (rsp_state_q == RSP_IDLE) || rsp_ready;
    assign accept    = req_valid && req_ready;

    // Address decode; misaligned or unmapped offsets select nothing
    always_comb begin
        sel = REG_NONE;
        if (req_addr[1:0] == 2'b00) begin
            if (req_addr == ADDR_W'(CLINT_MSIP_OFF)) begin
                sel = REG_MSIP;
            end else if (req_addr == ADDR_W'(CLINT_MTIMECMP_LO_OFF)) begin
                sel = REG_CMP_LO;
            end else if (req_addr == ADDR_W'(CLINT_MTIMECMP_HI_OFF)) begin
                sel = REG_CMP_HI;
            end else if (req_addr == ADDR_W'(CLINT_MTIME_LO_OFF)) begin
                sel = REG_TIME_LO;
            end else if (req_addr == ADDR_W'(CLINT_MTIME_HI_OFF)) begin
                sel = REG_TIME_HI;
            end
        end
    end

    // Current value of the selected register and its byte-merged write value
    always_comb begin
        rd_word = '0;
        case (sel)
            REG_MSIP:    rd_word = {31'b0, msip_q};
            REG_CMP_LO:  rd_word = mtimecmp_q[31:0];
            REG_CMP_HI:  rd_word = mtimecmp_q[63:32];
            REG_TIME_LO: rd_word = mtime_q[31:0];
            REG_TIME_HI: rd_word = mtime_q[63:32];
            default:     rd_word = '0;
        endcase
        wr_word = clint_merge(rd_word, req_wdata, req_wstrb);
    end

    // Register next state; a write to an mtime half overrides that cycle's tick
    always_comb begin
        mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d  = mtimecmp_q;
        msip_d      = msip_q;
        timer_irq_d = (mtime_q >= mtimecmp_q);
        if (accept && req_we) begin
            case (sel)
                REG_MSIP:    msip_d             = wr_word[0];
                REG_CMP_LO:  mtimecmp_d[31:0]   = wr_word;
                REG_CMP_HI:  mtimecmp_d[63:32]  = wr_word;
                REG_TIME_LO: mtime_d            = {mtime_q[63:32], wr_word};
                REG_TIME_HI: mtime_d            = {wr_word, mtime_q[31:0]};
                default:     ;
            endcase
        end
    end

    // Response channel: retire on handshake, reload on accept (accept wins)
    always_comb begin
        rsp_state_d = rsp_state_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (rsp_state_q)
            RSP_IDLE: ;
            RSP_PEND: begin
                if (rsp_ready) begin
                    rsp_state_d = RSP_IDLE;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: rsp_state_d = RSP_IDLE;
        endcase
        if (accept) begin
            rsp_state_d = RSP_PEND;
            rsp_rdata_d = (req_we || (sel == REG_NONE)) ? '0 : rd_word;
            rsp_err_d   = (sel == REG_NONE);
        end
    end

    // Timer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q     <= '0;
            mtimecmp_q  <= CLINT_MTIMECMP_RST;
            msip_q      <= 1'b0;
            timer_irq_q <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            timer_irq_q <= timer_irq_d;
        end
    end

    // Response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_state_q <= RSP_IDLE;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_state_q <= rsp_state_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = (rsp_state_q == RSP_PEND);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign timer_irq = timer_irq_q;
    assign sw_irq    = msip_q;

endmodule

// File: tb/tb_clint_timer.sv
// Self-checking bench for clint_timer. Expected responses come from a small
// behavioural model of the timer registers and are queued at request time.
module tb_clint_timer;

    localparam int unsigned PRESCALE = 4;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        rsp_ready = 1'b1;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        timer_irq;
    logic        sw_irq;

    int          tests = 0;
    int          fails = 0;
    logic [32:0] exp_q[$];

    clint_timer #(
        .ADDR_W  (16),
        .PRESCALE(PRESCALE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .timer_irq(timer_irq),
        .sw_irq   (sw_irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [63:0] m_mtime, m_cmp, m_mtime_nx, m_cmp_nx;
    logic        m_msip, m_msip_nx, m_irq, m_tick;
    int unsigned m_pre;

    function automatic logic [31:0] tb_merge(input logic [31:0] o, input logic [31:0] w,
                                             input logic [3:0] s);
        logic [31:0] r;
        r[7:0]   = s[0] ? w[7:0]   : o[7:0];
        r[15:8]  = s[1] ? w[15:8]  : o[15:8];
        r[23:16] = s[2] ? w[23:16] : o[23:16];
        r[31:24] = s[3] ? w[31:24] : o[31:24];
        return r;
    endfunction

    always_comb begin
`ifdef CLINT_PRESCALE_EN
        m_tick = (m_pre == PRESCALE - 1);
`else
        m_tick = 1'b1;
`endif
        m_mtime_nx = m_tick ? m_mtime + 64'd1 : m_mtime;
        m_cmp_nx   = m_cmp;
        m_msip_nx  = m_msip;
        if (req_valid && req_ready && req_we && req_addr[1:0] == 2'b00) begin
            case (req_addr)
                16'h0000: m_msip_nx = req_wstrb[0] ? req_wdata[0] : m_msip;
                16'h4000: m_cmp_nx[31:0]  = tb_merge(m_cmp[31:0], req_wdata, req_wstrb);
                16'h4004: m_cmp_nx[63:32] = tb_merge(m_cmp[63:32], req_wdata, req_wstrb);
                16'hBFF8: m_mtime_nx = {m_mtime[63:32], tb_merge(m_mtime[31:0], req_wdata, req_wstrb)};
                16'hBFFC: m_mtime_nx = {tb_merge(m_mtime[63:32], req_wdata, req_wstrb), m_mtime[31:0]};
                default: ;
            endcase
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mtime <= '0;
            m_cmp   <= '1;
            m_msip  <= 1'b0;
            m_irq   <= 1'b0;
            m_pre   <= 0;
        end else begin
            m_mtime <= m_mtime_nx;
            m_cmp   <= m_cmp_nx;
            m_msip  <= m_msip_nx;
            m_irq   <= (m_mtime >= m_cmp);
            m_pre   <= m_tick ? 0 : m_pre + 1;
        end
    end

    // {err, rdata} the slave must return if this request is accepted now
    function automatic logic [32:0] exp_read(input logic we, input logic [15:0] a);
        if (a[1:0] != 2'b00) return {1'b1, 32'h0};
        case (a)
            16'h0000: return {1'b0, we ? 32'h0 : {31'h0, m_msip}};
            16'h4000: return {1'b0, we ? 32'h0 : m_cmp[31:0]};
            16'h4004: return {1'b0, we ? 32'h0 : m_cmp[63:32]};
            16'hBFF8: return {1'b0, we ? 32'h0 : m_mtime[31:0]};
            16'hBFFC: return {1'b0, we ? 32'h0 : m_mtime[63:32]};
            default:  return {1'b1, 32'h0};
        endcase
    endfunction

    // ---------------- bus driver ----------------
    task automatic xfer(input op_t op, output logic [31:0] rd, output logic er);
        int unsigned n;
        req_we    = op.we;
        req_addr  = op.addr;
        req_wdata = op.wdata;
        req_wstrb = op.wstrb;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (req_ready !== 1'b1) begin
            tests++; fails++;
            $display("FAIL xfer_accept_timeout: req_ready=%b, required 1", req_ready);
        end
        exp_q.push_back(exp_read(op.we, op.addr));
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (rsp_valid !== 1'b1) begin
            tests++; fails++;
            $display("FAIL xfer_rsp_timeout: rsp_valid=%b, required 1", rsp_valid);
        end
        rd = rsp_rdata;
        er = rsp_err;
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        op_t         ops[3];
        logic [31:0] rd, rds[3];
        logic        er;
        logic [32:0] ex;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({rsp_valid, rsp_err, timer_irq, sw_irq, req_ready, rsp_rdata} !== {5'b00001, 32'h0}) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b e=%b ti=%b si=%b rdy=%b rd=%h, required 0 0 0 0 1 0",
                     rsp_valid, rsp_err, timer_irq, sw_irq, req_ready, rsp_rdata);
        end
        rst_n = 1'b1;
        ops = '{'{1'b1, 16'h0000, 32'h1, 4'hF}, '{1'b1, 16'h4004, 32'h0, 4'hF},
                '{1'b1, 16'h4000, 32'h0, 4'hF}};
        foreach (ops[i]) begin
            xfer(ops[i], rd, er);
            ex = exp_q.pop_front();
            tests++;
            if ({er, rd} !== ex) begin
                fails++;
                $display("FAIL reset_setup%0d: got err=%b rdata=%h, required err=%b rdata=%h", i, er, rd, ex[32], ex[31:0]);
            end
        end
        tests++;
        if (timer_irq !== 1'b1 || sw_irq !== 1'b1 || timer_irq !== m_irq) begin
            fails++;
            $display("FAIL reset_pre_irqs: got ti=%b si=%b, required 1 1", timer_irq, sw_irq);
        end
        // leave a response pending, then reset underneath it
        rsp_ready = 1'b0;
        req_we = 1'b0; req_addr = 16'h4004; req_wstrb = '0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        tests++;
        if (rsp_valid !== 1'b1) begin
            fails++;
            $display("FAIL reset_pending: rsp_valid=%b, required 1", rsp_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({rsp_valid, rsp_err, timer_irq, sw_irq, req_ready, rsp_rdata} !== {5'b00001, 32'h0}) begin
            fails++;
            $display("FAIL reset_midrun: got v=%b e=%b ti=%b si=%b rdy=%b rd=%h, required 0 0 0 0 1 0",
                     rsp_valid, rsp_err, timer_irq, sw_irq, req_ready, rsp_rdata);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        ops = '{'{1'b0, 16'hBFF8, 32'h0, 4'h0}, '{1'b0, 16'h4004, 32'h0, 4'h0},
                '{1'b0, 16'h0000, 32'h0, 4'h0}};
        foreach (ops[i]) begin
            xfer(ops[i], rd, er);
            rds[i] = rd;
            ex = exp_q.pop_front();
            tests++;
            if ({er, rd} !== ex) begin
                fails++;
                $display("FAIL reset_read%0d: got err=%b rdata=%h, required err=%b rdata=%h", i, er, rd, ex[32], ex[31:0]);
            end
        end
        tests++;
        if (rds[0] > 32'd8 || rds[1] !== 32'hFFFF_FFFF || rds[2] !== 32'h0) begin
            fails++;
            $display("FAIL reset_values: mtime_lo=%h cmp_hi=%h msip=%h, required <=8 FFFFFFFF 0", rds[0], rds[1], rds[2]);
        end
    endtask

    task automatic test_timer_irq();
        op_t         ops[3];
        logic [31:0] rd;
        logic        er, saw_lo, saw_hi;
        logic [32:0] ex;
        int unsigned n;
        ops = '{'{1'b1, 16'hBFF8, 32'h5, 4'hF}, '{1'b1, 16'h4000, 32'h20, 4'hF},
                '{1'b1, 16'h4004, 32'h0, 4'hF}};
        foreach (ops[i]) begin
            xfer(ops[i], rd, er);
            ex = exp_q.pop_front();
            tests++;
            if ({er, rd} !== ex) begin
                fails++;
                $display("FAIL timer_setup%0d: got err=%b rdata=%h, required err=%b rdata=%h", i, er, rd, ex[32], ex[31:0]);
            end
        end
        saw_lo = 1'b0; saw_hi = 1'b0; n = 0;
        while (m_mtime <= 64'h24 && n < 200) begin
            @(posedge clk); #1; n++;
            tests++;
            if (timer_irq !== m_irq) begin
                fails++;
                $display("FAIL timer_track: mtime=%0h timer_irq=%b, required %b", m_mtime, timer_irq, m_irq);
            end
            if (m_mtime == 64'h1F && timer_irq === 1'b0) saw_lo = 1'b1;
            if (m_mtime == 64'h21 && timer_irq === 1'b1) saw_hi = 1'b1;
        end
        tests++;
        if (!(saw_lo && saw_hi)) begin
            fails++;
            $display("FAIL timer_rise_at_20: low_before=%b high_after=%b, required 1 1", saw_lo, saw_hi);
        end
        xfer('{1'b1, 16'h4000, 32'hFFFF_FFFF, 4'hF}, rd, er);
        ex = exp_q.pop_front();
        tests++;
        if ({er, rd} !== ex || timer_irq !== 1'b0) begin
            fails++;
            $display("FAIL timer_clear: got err=%b rdata=%h ti=%b, required err=%b rdata=%h ti=0", er, rd, timer_irq, ex[32], ex[31:0]);
        end
    endtask

    task automatic test_sw_irq();
        op_t         ops[4];
        logic        exp_sw[4];
        logic [31:0] rd;
        logic        er;
        logic [32:0] ex;
        ops = '{'{1'b1, 16'h0000, 32'h1, 4'hF}, '{1'b0, 16'h0000, 32'h0, 4'h0},
                '{1'b1, 16'h0000, 32'hFFFF_FFFE, 4'hF}, '{1'b0, 16'h0000, 32'h0, 4'h0}};
        exp_sw = '{1'b1, 1'b1, 1'b0, 1'b0};
        foreach (ops[i]) begin
            xfer(ops[i], rd, er);
            ex = exp_q.pop_front();
            tests++;
            if ({er, rd} !== ex || sw_irq !== exp_sw[i]) begin
                fails++;
                $display("FAIL sw_irq%0d: got err=%b rdata=%h si=%b, required err=%b rdata=%h si=%b",
                         i, er, rd, sw_irq, ex[32], ex[31:0], exp_sw[i]);
            end
        end
    endtask

    task automatic test_wrap_partial();
        op_t         ops[7];
        logic [31:0] rd, rds[7];
        logic        er;
        logic [32:0] ex;
        ops = '{'{1'b1, 16'hBFFC, 32'hFFFF_FFFF, 4'hF}, '{1'b1, 16'hBFF8, 32'hFFFF_FFFE, 4'hF},
                '{1'b0, 16'hBFFC, 32'h0, 4'h0}, '{1'b0, 16'hBFF8, 32'h0, 4'h0},
                '{1'b1, 16'hBFF8, 32'h1122_3344, 4'hF}, '{1'b1, 16'hBFF8, 32'hAABB_CCDD, 4'b0010},
                '{1'b0, 16'hBFF8, 32'h0, 4'h0}};
        foreach (ops[i]) begin
            if (i == 2) begin
                repeat (10) @(posedge clk);
                #1;
            end
            xfer(ops[i], rd, er);
            rds[i] = rd;
            ex = exp_q.pop_front();
            tests++;
            if ({er, rd} !== ex) begin
                fails++;
                $display("FAIL wrap_partial%0d: got err=%b rdata=%h, required err=%b rdata=%h", i, er, rd, ex[32], ex[31:0]);
            end
        end
        tests++;
        if (rds[2] !== 32'h0 || rds[3] > 32'd16) begin
            fails++;
            $display("FAIL wrap_to_zero: hi=%h lo=%h, required hi=0 lo<=16", rds[2], rds[3]);
        end
        tests++;
        if (rds[6][31:8] !== 24'h1122CC || rds[6][7:0] < 8'h44) begin
            fails++;
            $display("FAIL partial_byte1: lo=%h, required 1122CCxx with xx>=44", rds[6]);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        logic [32:0] ex;
        rsp_ready = 1'b0;
        req_we = 1'b0; req_addr = 16'h4004; req_wstrb = '0; req_valid = 1'b1;
        exp_q.push_back(exp_read(1'b0, 16'h4004));
        @(posedge clk); #1;
        req_addr = 16'h4000;
        held = rsp_rdata;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== held || rsp_rdata !== exp_q[0][31:0]) begin
                fails++;
                $display("FAIL bp_hold%0d: rdy=%b v=%b rdata=%h, required 0 1 %h", k, req_ready, rsp_valid, rsp_rdata, exp_q[0][31:0]);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release_ready: req_ready=%b, required 1", req_ready);
        end
        exp_q.push_back(exp_read(1'b0, 16'h4000));
        held = rsp_rdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        ex = exp_q.pop_front();
        tests++;
        if ({1'b0, held} !== ex) begin
            fails++;
            $display("FAIL bp_first: rdata=%h, required %h", held, ex[31:0]);
        end
        ex = exp_q.pop_front();
        tests++;
        if (rsp_valid !== 1'b1 || {rsp_err, rsp_rdata} !== ex) begin
            fails++;
            $display("FAIL bp_second: v=%b err=%b rdata=%h, required 1 %b %h", rsp_valid, rsp_err, rsp_rdata, ex[32], ex[31:0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [15:0] addrs[5];
        logic [32:0] ex;
        addrs = '{16'h4000, 16'h4004, 16'h0000, 16'hBFF8, 16'h0100};
        rsp_ready = 1'b1;
        req_we = 1'b0; req_wstrb = '0;
        foreach (addrs[i]) begin
            req_addr = addrs[i];
            req_valid = 1'b1;
            exp_q.push_back(exp_read(1'b0, addrs[i]));
            @(posedge clk); #1;
            ex = exp_q.pop_front();
            tests++;
            if (rsp_valid !== 1'b1 || {rsp_err, rsp_rdata} !== ex) begin
                fails++;
                $display("FAIL b2b%0d: v=%b err=%b rdata=%h, required 1 %b %h", i, rsp_valid, rsp_err, rsp_rdata, ex[32], ex[31:0]);
            end
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_errors();
        op_t         ops[6];
        logic [31:0] rd, rds[6];
        logic        er, ers[6];
        logic [32:0] ex;
        ops = '{'{1'b0, 16'h0100, 32'h0, 4'h0}, '{1'b0, 16'h4002, 32'h0, 4'h0},
                '{1'b1, 16'h0104, 32'h1, 4'hF}, '{1'b1, 16'h4000, 32'h1234_5678, 4'h0},
                '{1'b0, 16'h4000, 32'h0, 4'h0}, '{1'b0, 16'h0000, 32'h0, 4'h0}};
        foreach (ops[i]) begin
            xfer(ops[i], rd, er);
            rds[i] = rd; ers[i] = er;
            ex = exp_q.pop_front();
            tests++;
            if ({er, rd} !== ex) begin
                fails++;
                $display("FAIL err%0d: got err=%b rdata=%h, required err=%b rdata=%h", i, er, rd, ex[32], ex[31:0]);
            end
        end
        tests++;
        if (ers[0] !== 1'b1 || rds[0] !== 32'h0 || ers[1] !== 1'b1 || ers[2] !== 1'b1 || ers[3] !== 1'b0
            || rds[4] !== 32'hFFFF_FFFF || rds[5] !== 32'h0 || sw_irq !== 1'b0) begin
            fails++;
            $display("FAIL err_summary: e0=%b r0=%h e1=%b e2=%b e3=%b cmp_lo=%h msip=%h si=%b, required 1 0 1 1 0 FFFFFFFF 0 0",
                     ers[0], rds[0], ers[1], ers[2], ers[3], rds[4], rds[5], sw_irq);
        end
    endtask

`ifdef CLINT_PRESCALE_EN
    task automatic test_prescaler();
        op_t         ops[4];
        logic [31:0] rd;
        logic        er, saw0, saw1;
        logic [32:0] ex;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (39) @(posedge clk);
        #1;
        ops = '{'{1'b0, 16'hBFF8, 32'h0, 4'h0}, '{1'b1, 16'hBFF8, 32'h0, 4'hF},
                '{1'b1, 16'h4004, 32'h0, 4'hF}, '{1'b1, 16'h4000, 32'h8, 4'hF}};
        foreach (ops[i]) begin
            xfer(ops[i], rd, er);
            ex = exp_q.pop_front();
            tests++;
            if ({er, rd} !== ex || (i == 0 && (rd < 32'd9 || rd > 32'd11))) begin
                fails++;
                $display("FAIL presc%0d: got err=%b rdata=%h, required err=%b rdata=%h", i, er, rd, ex[32], ex[31:0]);
            end
        end
        saw0 = 1'b0; saw1 = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            tests++;
            if (timer_irq !== m_irq) begin
                fails++;
                $display("FAIL presc_irq: mtime=%0h timer_irq=%b, required %b", m_mtime, timer_irq, m_irq);
            end
            if (timer_irq === 1'b0) saw0 = 1'b1;
            if (timer_irq === 1'b1 && saw0) saw1 = 1'b1;
        end
        tests++;
        if (!(saw0 && saw1)) begin
            fails++;
            $display("FAIL presc_rise: low=%b high=%b, required 1 1", saw0, saw1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_timer_irq();
        test_sw_irq();
        test_wrap_partial();
        test_backpressure();
        test_back_to_back();
        test_errors();
`ifdef CLINT_PRESCALE_EN
        test_prescaler();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
